// File: rtl/care_pkg.sv
// care_pkg: state encoding and default timing constants for the pulse front end.
// Rev 1.0
`default_nettype none

package care_pkg;

    localparam int CLK_HZ            = 1000000;
    localparam int WINDOW_CYCLES     = 15000000;
    localparam int DEBOUNCE_CYCLES   = 2000;
    localparam int REFRACTORY_CYCLES = 250000;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } win_state_e;

endpackage

`default_nettype wire

// File: rtl/pulse_debouncer.sv
// pulse_debouncer: 2-flop synchroniser, debounce counter, registered rise strobe.
// Rev 1.0
`default_nettype none

module pulse_debouncer #(
    parameter int DEBOUNCE_CYCLES = care_pkg::DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic pulse_i,
    output logic deb_o,
    output logic rise_o
);
    import care_pkg::*;

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             deb_q, deb_d;
    logic             deb_prev_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            meta_q     <= pulse_i;
            sync_q     <= meta_q;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            deb_prev_q <= deb_q;
            rise_q     <= deb_q & ~deb_prev_q;
        end
    end

    assign deb_o  = deb_q;
    assign rise_o = rise_q;

endmodule

`default_nettype wire

// File: rtl/pulse_window_counter.sv
// pulse_window_counter: refractory-gated beat counter over back-to-back fixed windows.
// Rev 1.0
`default_nettype none

module pulse_window_counter #(
    parameter int WINDOW_CYCLES     = care_pkg::WINDOW_CYCLES,
    parameter int DEBOUNCE_CYCLES   = care_pkg::DEBOUNCE_CYCLES,
    parameter int REFRACTORY_CYCLES = care_pkg::REFRACTORY_CYCLES,
    parameter int COUNT_W           = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               pulse_in,
    output logic [COUNT_W-1:0] pulse_count,
    output logic               count_valid,
    output logic               saturated,
    output logic               pulse_seen,
    output logic               window_active
);
    import care_pkg::*;

    localparam int                 WIN_W     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int                 REFR_W    = $clog2(REFRACTORY_CYCLES + 1);
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [REFR_W-1:0]  REFR_LOAD = REFR_W'(REFRACTORY_CYCLES - 1);
    localparam logic [COUNT_W-1:0] ACC_MAX   = {COUNT_W{1'b1}};

    logic               deb;
    logic               rise;
    logic               beat;
    logic               acc_full;

    win_state_e         state_q, state_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [COUNT_W-1:0] acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [REFR_W-1:0]  refr_q, refr_d;
    logic [COUNT_W-1:0] pulse_count_q, pulse_count_d;
    logic               saturated_q, saturated_d;
    logic               count_valid_q, count_valid_d;
    logic               pulse_seen_q;
    logic               window_active_q;

    pulse_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .reset  (reset),
        .pulse_i(pulse_in),
        .deb_o  (deb),
        .rise_o (rise)
    );

    // The rise strobe trails the level by one cycle; the level is still high then.
    assign beat     = rise && deb && (refr_q == '0) && (state_q == COUNTING);
    assign acc_full = (acc_q == ACC_MAX);

    always_comb begin
        refr_d = refr_q;
        if (beat) begin
            refr_d = REFR_LOAD;
        end else if (refr_q != '0) begin
            refr_d = refr_q - 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        win_cnt_d     = win_cnt_q;
        acc_d         = acc_q;
        ovf_d         = ovf_q;
        pulse_count_d = pulse_count_q;
        saturated_d   = saturated_q;
        count_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                win_cnt_d = '0;
                acc_d     = '0;
                ovf_d     = 1'b0;
                if (enable) begin
                    state_d = COUNTING;
                end
            end
            COUNTING: begin
                if (!enable) begin
                    state_d   = IDLE;
                    win_cnt_d = '0;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                end else if (win_cnt_q == WIN_LAST) begin
                    // A beat landing in the final cycle still belongs to this window.
                    pulse_count_d = (beat && !acc_full) ? acc_q + 1'b1 : acc_q;
                    saturated_d   = ovf_q | (beat & acc_full);
                    count_valid_d = 1'b1;
                    win_cnt_d     = '0;
                    acc_d         = '0;
                    ovf_d         = 1'b0;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                    if (beat) begin
                        if (acc_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = acc_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            win_cnt_q       <= '0;
            acc_q           <= '0;
            ovf_q           <= 1'b0;
            refr_q          <= '0;
            pulse_count_q   <= '0;
            saturated_q     <= 1'b0;
            count_valid_q   <= 1'b0;
            pulse_seen_q    <= 1'b0;
            window_active_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            win_cnt_q       <= win_cnt_d;
            acc_q           <= acc_d;
            ovf_q           <= ovf_d;
            refr_q          <= refr_d;
            pulse_count_q   <= pulse_count_d;
            saturated_q     <= saturated_d;
            count_valid_q   <= count_valid_d;
            pulse_seen_q    <= beat;
            window_active_q <= (state_d == COUNTING);
        end
    end

    assign pulse_count   = pulse_count_q;
    assign count_valid   = count_valid_q;
    assign saturated     = saturated_q;
    assign pulse_seen    = pulse_seen_q;
    assign window_active = window_active_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_window_counter.sv
// tb_pulse_window_counter: randomized stimulus against a timeline model, two counter widths.
// Rev 1.0
`default_nettype none

module tb_pulse_window_counter;

    localparam int W = 1000;
    localparam int D = 4;
    localparam int R = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       pulse_in = 1'b0;

    logic [7:0] pc8;
    logic       cv8, sat8, ps8, wa8;
    logic [3:0] pc4;
    logic       cv4, sat4, ps4, wa4;

    always #5 clk = ~clk;

    pulse_window_counter #(
        .WINDOW_CYCLES(W), .DEBOUNCE_CYCLES(D), .REFRACTORY_CYCLES(R), .COUNT_W(8)
    ) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
        .pulse_count(pc8), .count_valid(cv8), .saturated(sat8),
        .pulse_seen(ps8), .window_active(wa8)
    );

    pulse_window_counter #(
        .WINDOW_CYCLES(W), .DEBOUNCE_CYCLES(D), .REFRACTORY_CYCLES(R), .COUNT_W(4)
    ) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
        .pulse_count(pc4), .count_valid(cv4), .saturated(sat4),
        .pulse_seen(ps4), .window_active(wa4)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timeline view: every clk edge k has a sampled pulse_in value p[k]. The level
    // flips at edge k when the D synchronised samples p[k-D-1..k-2] all disagree
    // with it; a rise at edge r becomes a beat at edge r+2 if the previous accepted
    // beat is at least R edges earlier and a window is open.
    bit hist [0:65535];
    int k = 0, rst_k = 0;
    int deb_m = 0, last_rise = -100, last_beat = -1000000;
    int st = 0, wc = 0, tot = 0;
    int e_cnt8 = 0, e_cnt4 = 0, e_sat8 = 0, e_sat4 = 0, e_cv = 0, e_ps = 0, e_wa = 0;

    function automatic int pv(input int i);
        if (i < rst_k || i < 0) return 0;
        return int'(hist[i & 65535]);
    endfunction

    function automatic int clampv(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        rst_k = k; deb_m = 0; last_rise = -100; last_beat = -1000000;
        st = 0; wc = 0; tot = 0;
        e_cnt8 = 0; e_cnt4 = 0; e_sat8 = 0; e_sat4 = 0; e_cv = 0; e_ps = 0; e_wa = 0;
    endtask

    task automatic model_edge();
        int  beat;
        bit  all_diff;
        hist[k & 65535] = pulse_in;
        beat = (last_rise == k - 2 && st == 1 && k - last_beat >= R) ? 1 : 0;
        if (beat != 0) last_beat = k;
        e_ps = beat;
        e_cv = 0;
        if (st == 0) begin
            if (enable) begin st = 1; wc = 0; tot = 0; end
        end else if (!enable) begin
            st = 0;
        end else begin
            tot += beat;
            if (wc == W - 1) begin
                e_cv   = 1;
                e_cnt8 = clampv(tot, 255);
                e_sat8 = (tot > 255) ? 1 : 0;
                e_cnt4 = clampv(tot, 15);
                e_sat4 = (tot > 15) ? 1 : 0;
                tot = 0; wc = 0;
            end else begin
                wc++;
            end
        end
        e_wa = st;
        all_diff = 1'b1;
        for (int i = k - D - 1; i <= k - 2; i++)
            if (pv(i) == deb_m) all_diff = 1'b0;
        if (all_diff) begin
            deb_m = 1 - deb_m;
            if (deb_m == 1) last_rise = k;
        end
        k++;
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) model_reset();
        else       model_edge();
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle comparison, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("pulse_count8",  int'(pc8),  e_cnt8);
        chk("pulse_count4",  int'(pc4),  e_cnt4);
        chk("saturated8",    int'(sat8), e_sat8);
        chk("saturated4",    int'(sat4), e_sat4);
        chk("count_valid8",  int'(cv8),  e_cv);
        chk("count_valid4",  int'(cv4),  e_cv);
        chk("pulse_seen8",   int'(ps8),  e_ps);
        chk("pulse_seen4",   int'(ps4),  e_ps);
        chk("window_active8", int'(wa8), e_wa);
        chk("window_active4", int'(wa4), e_wa);
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input int h, input int l, output int lat);
        @(posedge clk); #1;
        pulse_in = 1'b1;
        lat = -1;
        for (int i = 0; i < h + l; i++) begin
            @(posedge clk); #1;
            if (lat < 0 && ps8) lat = i;
            if (i == h - 1) pulse_in = 1'b0;
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!cv8 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("count_valid arrives", int'(cv8), 1);
    endtask

    initial begin
        int lat, lat2, c0, t_en;
        #2 reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset pulse_count", int'(pc8), 0);
        chk("reset count_valid", int'(cv8), 0);
        chk("reset window_active", int'(wa8), 0);
        chk("reset pulse_seen", int'(ps8), 0);
        reset  = 1'b0;
        enable = 1'b1;

        // Clean pulses: each strobe 7 edges after the first edge that samples high.
        for (int i = 0; i < 10; i++) begin
            pulse(10, 39 + int'($urandom_range(0, 4)), lat);
            chk("clean latency", lat, 7);
        end
        wait_valid();
        chk("clean count", int'(pc8), 10);
        chk("clean saturated", int'(sat8), 0);

        // Glitches shorter than the debounce length.
        for (int i = 0; i < 20; i++) pulse(3, 26, lat);
        wait_valid();
        chk("glitch count", int'(pc8), 0);

        // Second rise 12 edges after the first falls inside the refractory interval.
        pulse(6, 5, lat);
        pulse(6, 30, lat2);
        chk("refractory first latency", lat, 7);
        chk("refractory second dropped", lat2, -1);
        wait_valid();
        chk("refractory count", int'(pc8), 1);

        // Saturation of the 4-bit accumulator.
        for (int i = 0; i < 20; i++) pulse(10, 29, lat);
        wait_valid();
        chk("sat count4", int'(pc4), 15);
        chk("sat flag4", int'(sat4), 1);
        chk("sat count8", int'(pc8), 20);
        chk("sat flag8", int'(sat8), 0);
        wait_valid();
        chk("empty count4", int'(pc4), 0);
        chk("empty flag4", int'(sat4), 0);

        // Enable abort mid-window; the next publish is one full window after re-enable.
        c0 = cyc;
        for (int i = 0; i < 5; i++) pulse(10, 39, lat);
        while (cyc - c0 < 500) begin @(posedge clk); #1; end
        enable = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        enable = 1'b1;
        t_en = cyc;
        for (int i = 0; i < 3; i++) pulse(10, 39, lat);
        wait_valid();
        // Enable is sampled one edge after it is driven, so the strobe lands at W+1.
        chk("abort publish delay", cyc - t_en, W + 1);
        chk("abort count", int'(pc8), 3);

        // Asynchronous reset with a published count held.
        for (int i = 0; i < 10; i++) pulse(10, 39, lat);
        wait_valid();
        chk("pre-reset count", int'(pc8), 10);
        repeat (300) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        chk("async pulse_count8", int'(pc8), 0);
        chk("async pulse_count4", int'(pc4), 0);
        chk("async window_active", int'(wa8), 0);
        chk("async count_valid", int'(cv8), 0);
        chk("async saturated", int'(sat8), 0);
        chk("async pulse_seen", int'(ps8), 0);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("idle window_active", int'(wa8), 0);
        enable = 1'b1;
        @(posedge clk); #1;
        chk("window_active after enable", int'(wa8), 1);

        // Random soak: arbitrary levels and hold times, rare enable toggles.
        for (int s = 0; s < 250; s++) begin
            pulse_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            repeat ($urandom_range(1, 40)) @(posedge clk);
            #1;
        end
        pulse_in = 1'b0;
        enable   = 1'b1;
        for (int i = 0; i < 8; i++) pulse(10, 20 + int'($urandom_range(0, 60)), lat);
        wait_valid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
